// File: rtl/sub32_seq_pkg.sv
// Shared ALU definitions: datapath widths and the sequential-subtractor state encoding.
// Imported by the subtractor top and by the 16-bit add slice.
package sub32_seq_pkg;

    localparam int DATA_W  = 32;
    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sub32_seq_add16.sv
// 16-bit add slice with carry in/out; purely combinational, no handshake.
// Shared by the low and high passes of the sequential subtractor.
module add16
    import sub32_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               carry_in,
    output logic [SLICE_W-1:0] sum,
    output logic               carry_out
);

    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, carry_in};

endmodule

// File: rtl/sub32_seq.sv
// 32-bit a - b over one shared 16-bit add slice (low pass, then high pass); result 3 cycles after accept.
// valid/ready both sides; result held stable in DONE until out_ready, new operands accepted on that same edge.
module sub32_seq
    import sub32_seq_pkg::*;
#(
    parameter int SLICE_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] diff,
    output logic              borrow,
    output logic              overflow
);

    state_t              r_state;
    state_t              w_next;

    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_nb;
    logic [SLICE_W-1:0]  r_lo;
    logic                r_carry_lo;
    logic [DATA_W-1:0]   r_diff;
    logic                r_borrow;
    logic                r_overflow;

    logic [SLICE_W-1:0]  w_sa;
    logic [SLICE_W-1:0]  w_sb;
    logic                w_cin;
    logic [SLICE_W-1:0]  w_sum;
    logic                w_cout;
    logic                w_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = LOW;
            LOW:     w_next = HIGH;
            HIGH:    w_next = DONE;
            DONE:    if (out_ready) w_next = in_valid ? LOW : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
        out_valid = (r_state == DONE);
    end

    assign w_accept = in_valid && in_ready;

    // Subtraction as a + ~b + 1: the +1 enters as the low-pass carry_in.
    always_comb begin
        w_sa  = r_a[SLICE_W-1:0];
        w_sb  = r_nb[SLICE_W-1:0];
        w_cin = 1'b1;
        if (r_state == HIGH) begin
            w_sa  = r_a[DATA_W-1:SLICE_W];
            w_sb  = r_nb[DATA_W-1:SLICE_W];
            w_cin = r_carry_lo;
        end
    end

    add16 u_slice (
        .a         (w_sa),
        .b         (w_sb),
        .carry_in  (w_cin),
        .sum       (w_sum),
        .carry_out (w_cout)
    );

    // The low half is parked in r_lo so diff only changes once, as a whole, at the end of HIGH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_nb       <= '0;
            r_lo       <= '0;
            r_carry_lo <= 1'b0;
            r_diff     <= '0;
            r_borrow   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a  <= a;
                r_nb <= ~b;
            end
            if (r_state == LOW) begin
                r_lo       <= w_sum;
                r_carry_lo <= w_cout;
            end
            if (r_state == HIGH) begin
                r_diff     <= {w_sum, r_lo};
                r_borrow   <= ~w_cout;
                r_overflow <= (r_a[DATA_W-1] != ~r_nb[DATA_W-1]) &&
                              (w_sum[SLICE_W-1] != r_a[DATA_W-1]);
            end
        end
    end

    assign diff     = r_diff;
    assign borrow   = r_borrow;
    assign overflow = r_overflow;

endmodule
